// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache sequencer: one access, or two for LDI/STI, with byte-lane
// handling. The pipeline stalls until the final response and then advances once.
module mem_stage_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             dcacheR,
    input  logic             dcacheW,
    input  logic             ldi_op,
    input  logic             sti_op,
    input  logic             ldb_op,
    input  logic             stb_op,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] dmem_address,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [1:0]       dmem_byte_en,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_resp,
    output logic [WIDTH-1:0] mem_rdata,
    output logic             mem_stall
);

    localparam int BW = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, PTR, ACC, DONE} state_e;

    state_e           state_q, state_d;
    logic             rd_q, rd_d;
    logic             ldb_q, ldb_d;
    logic             stb_q, stb_d;
    logic             lane_q, lane_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    logic [WIDTH-1:0] daddr_q, daddr_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [1:0]       be_q, be_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             req;
    logic             load_access;
    logic [WIDTH-1:0] acc_src;
    logic             acc_rd;
    logic             acc_stb;
    logic [WIDTH-1:0] acc_data;

    function automatic logic [WIDTH-1:0] word_addr(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:1], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] store_wdata(input logic is_byte,
                                                     input logic [WIDTH-1:0] d);
        return is_byte ? {d[BW-1:0], d[BW-1:0]} : d;
    endfunction

    function automatic logic [WIDTH-1:0] load_fmt(input logic is_byte, input logic lane,
                                                  input logic [WIDTH-1:0] d);
        if (!is_byte) return d;
        return lane ? {{BW{1'b0}}, d[WIDTH-1:BW]} : {{BW{1'b0}}, d[BW-1:0]};
    endfunction

    assign req = valid_in & (dcacheR | dcacheW);

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        ldb_d       = ldb_q;
        stb_d       = stb_q;
        lane_d      = lane_q;
        sdata_d     = sdata_q;
        daddr_d     = daddr_q;
        read_d      = read_q;
        write_d     = write_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        load_access = 1'b0;

        // The final access is set up either straight from EX/MEM (IDLE) or
        // from the pointer arriving on dmem_rdata (PTR) using latched op bits.
        acc_src  = (state_q == PTR) ? dmem_rdata : addr;
        acc_rd   = (state_q == IDLE) ? dcacheR : rd_q;
        acc_stb  = (state_q == IDLE) ? stb_op : stb_q;
        acc_data = (state_q == IDLE) ? store_data : sdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    rd_d    = dcacheR;
                    ldb_d   = ldb_op;
                    stb_d   = stb_op;
                    sdata_d = store_data;
                    if (ldi_op | sti_op) begin
                        state_d = PTR;
                        daddr_d = word_addr(addr);
                        read_d  = 1'b1;
                        write_d = 1'b0;
                        be_d    = 2'b11;
                    end else begin
                        state_d     = ACC;
                        load_access = 1'b1;
                    end
                end
            end
            PTR: begin
                if (dmem_resp) begin
                    state_d     = ACC;
                    load_access = 1'b1;
                end
            end
            ACC: begin
                if (dmem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (rd_q) rdata_d = load_fmt(ldb_q, lane_q, dmem_rdata);
                end
            end
            DONE: state_d = IDLE;
        endcase

        if (load_access) begin
            daddr_d = word_addr(acc_src);
            lane_d  = acc_src[0];
            read_d  = acc_rd;
            write_d = ~acc_rd;
            be_d    = (!acc_rd && acc_stb) ? (acc_src[0] ? 2'b10 : 2'b01) : 2'b11;
            wdata_d = store_wdata(acc_stb, acc_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            ldb_q   <= 1'b0;
            stb_q   <= 1'b0;
            lane_q  <= 1'b0;
            sdata_q <= '0;
            daddr_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            ldb_q   <= ldb_d;
            stb_q   <= stb_d;
            lane_q  <= lane_d;
            sdata_q <= sdata_d;
            daddr_q <= daddr_d;
            read_q  <= read_d;
            write_q <= write_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem_address = daddr_q;
    assign dmem_read    = read_q;
    assign dmem_write   = write_q;
    assign dmem_byte_en = be_q;
    assign dmem_wdata   = wdata_q;
    assign mem_rdata    = rdata_q;
    assign mem_stall    = ((state_q == IDLE) && req) || (state_q == PTR) || (state_q == ACC);

endmodule
